pmod_button_reader: RTL

Debounced multi-button input reader for the iCEstick PMOD header. It handles the input direction of the board's user I/O, where the LED drivers handle output. Each raw mechanical button is synchronised and debounced, and the reader emits a stable level plus single-cycle press, release and long-press events. It also encodes the most recently pressed button as a binary index, so downstream logic (LED patterns, mode selection) can use button events directly.

---
 rtl/pmod_btn_pkg.sv | 21 ++
 rtl/button_channel.sv | 117 +++++++++++
 rtl/pmod_button_reader.sv | 73 +++++++
 3 files changed

// File: rtl/pmod_btn_pkg.sv
// Shared types and default timing for the PMOD button reader.
// Defaults assume the 12 MHz iCEstick clock.
package pmod_btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 120000;   // 10 ms
    localparam int DEF_LONG_CYCLES     = 12000000; // 1 s

    // Width of a channel index; a single channel still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce state machine, and long-press timer.
// Emits a registered debounced level and one-cycle press/release/long-press pulses.
module button_channel
    import pmod_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);

    localparam logic          RELEASED = ACTIVE_LOW;
    localparam logic [DW-1:0] D_ONE    = 1;
    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_ONE    = 1;
    localparam logic [LW-1:0] L_LAST   = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] L_PRE    = LW'(LONG_CYCLES - 2);

    logic [1:0]    sync_q;
    logic          s;
    btn_state_e    state_q;
    logic [DW-1:0] dcnt_q;
    logic [LW-1:0] lcnt_q;
    logic          held_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    // NOTE: the synchroniser resets to the released pin level rather than zero,
    // otherwise an active-low button would look pressed straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RELEASED}};
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Normalised to 1 = pressed.
    assign s = sync_q[1] ^ RELEASED;

    // NOTE: every register here uses <= so all next values come from the same
    // pre-edge state; the pulses default low each cycle, giving one-cycle width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        dcnt_q  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                    end else if (dcnt_q == D_LAST) begin
                        state_q <= HELD;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        lcnt_q  <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + D_ONE;
                    end
                end
                HELD: begin
                    // Saturation at L_LAST makes long_press fire once per hold.
                    if (lcnt_q != L_LAST) lcnt_q <= lcnt_q + L_ONE;
                    if (lcnt_q == L_PRE)  long_q <= 1'b1;
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        dcnt_q  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // lcnt is left alone so a release bounce only pauses it.
                    if (s) begin
                        state_q <= HELD;
                    end else if (dcnt_q == D_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + D_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o      = held_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/pmod_button_reader.sv
// Debounced multi-button reader for the iCEstick PMOD header: per-channel
// debounce plus a fixed-priority index of the most recently pressed button.
module pmod_button_reader
    import pmod_btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1,
    localparam int IW             = idx_width(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_state_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_press_o,
    output logic [IW-1:0]    last_idx_o,
    output logic             last_valid_o
);

    logic [N_BTN-1:0] press_w;
    logic [IW-1:0]    first_idx;
    logic [IW-1:0]    last_idx_d,   last_idx_q;
    logic             last_valid_d, last_valid_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .btn_i        (btn_i[i]),
            .state_o      (btn_state_o[i]),
            .press_o      (press_w[i]),
            .release_o    (release_o[i]),
            .long_press_o (long_press_o[i])
        );
    end

    // NOTE: first_idx gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        first_idx = '0;
        // Descending scan: the lowest-numbered pulsing channel is written last.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_w[i]) first_idx = IW'(i);
        end
    end

    // The encoder reads the registered press pulses directly, so last_idx and
    // last_valid change in the same cycle the press pulse is visible.
    assign last_idx_d   = (|press_w) ? first_idx : last_idx_q;
    assign last_valid_d = last_valid_q | (|press_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign press_o      = press_w;
    assign last_idx_o   = last_idx_d;
    assign last_valid_o = last_valid_d;

endmodule
